// File: rtl/md5_rotadd_stage.sv
// md5_rotadd_stage: two-stage MD5 step back-end, new B = B + ROTL(A + sum, s).
// Stage 1 forms t = A + sum and looks up the per-step rotate amount.
// Stage 2 rotates t and adds B.
// A 6-bit step counter tracks the position within a 64-step block.
// Optional macro MD5_ROTADD_SEQ_CHECK_EN adds a sticky seq_err output.
// That output flags out-of-sequence in_first usage.
module md5_rotadd_stage #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_first,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_b,
    output logic [5:0]       out_round,
    output logic             out_last
`ifdef MD5_ROTADD_SEQ_CHECK_EN
    ,
    output logic             seq_err
`endif
);

    // MD5 per-step rotate amount, indexed by {group, position}
    function automatic logic [4:0] rot_amt(input logic [5:0] idx);
        logic [4:0] r;
        r = 5'd0;
        case ({idx[5:4], idx[1:0]})
            4'h0: r = 5'd7;
            4'h1: r = 5'd12;
            4'h2: r = 5'd17;
            4'h3: r = 5'd22;
            4'h4: r = 5'd5;
            4'h5: r = 5'd9;
            4'h6: r = 5'd14;
            4'h7: r = 5'd20;
            4'h8: r = 5'd4;
            4'h9: r = 5'd11;
            4'hA: r = 5'd16;
            4'hB: r = 5'd23;
            4'hC: r = 5'd6;
            4'hD: r = 5'd10;
            4'hE: r = 5'd15;
            4'hF: r = 5'd21;
            default: r = 5'd0;
        endcase
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] x, input logic [4:0] s);
        logic [2*WIDTH-1:0] d;
        d = {x, x} << s;
        return d[2*WIDTH-1:WIDTH];
    endfunction

    // Stage 1 registers
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_t_q, s1_t_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic [5:0]       s1_idx_q, s1_idx_d;
    logic [4:0]       s1_s_q, s1_s_d;
    logic             s1_last_q, s1_last_d;

    // Stage 2 (output) registers
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_b_q, out_b_d;
    logic [5:0]       out_round_q, out_round_d;
    logic             out_last_q, out_last_d;

    // Step counter
    logic [5:0]       cnt_q, cnt_d;

    logic             s2_load;
    logic             s1_load;
    logic             accept;
    logic [5:0]       idx;

    assign s2_load  = !out_valid_q || out_ready;
    assign s1_load  = !s1_valid_q || s2_load;
    assign in_ready = s1_load;
    assign accept   = in_valid && s1_load;
    assign idx      = in_first ? 6'd0 : cnt_q;

    assign out_valid = out_valid_q;
    assign out_b     = out_b_q;
    assign out_round = out_round_q;
    assign out_last  = out_last_q;

    // Next-state for both pipeline stages and the step counter
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_t_d      = s1_t_q;
        s1_b_d      = s1_b_q;
        s1_idx_d    = s1_idx_q;
        s1_s_d      = s1_s_q;
        s1_last_d   = s1_last_q;
        out_valid_d = out_valid_q;
        out_b_d     = out_b_q;
        out_round_d = out_round_q;
        out_last_d  = out_last_q;
        cnt_d       = cnt_q;

        if (s2_load) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_b_d     = s1_b_q + rotl(s1_t_q, s1_s_q);
                out_round_d = s1_idx_q;
                out_last_d  = s1_last_q;
            end
        end

        if (s1_load) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_t_d    = in_a + in_sum;
                s1_b_d    = in_b;
                s1_idx_d  = idx;
                s1_s_d    = rot_amt(idx);
                s1_last_d = (idx == 6'd63);
            end
        end

        if (accept) begin
            cnt_d = idx + 6'd1;
        end
    end

    // Pipeline and counter state, cleared asynchronously
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_t_q      <= '0;
            s1_b_q      <= '0;
            s1_idx_q    <= '0;
            s1_s_q      <= '0;
            s1_last_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_b_q     <= '0;
            out_round_q <= '0;
            out_last_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_t_q      <= s1_t_d;
            s1_b_q      <= s1_b_d;
            s1_idx_q    <= s1_idx_d;
            s1_s_q      <= s1_s_d;
            s1_last_q   <= s1_last_d;
            out_valid_q <= out_valid_d;
            out_b_q     <= out_b_d;
            out_round_q <= out_round_d;
            out_last_q  <= out_last_d;
            cnt_q       <= cnt_d;
        end
    end

`ifdef MD5_ROTADD_SEQ_CHECK_EN
    logic started_q, started_d;
    logic seq_err_q, seq_err_d;

    assign seq_err = seq_err_q;

    // Sticky sequencing error: restart mid-block, or a block continued past step 63
    always_comb begin
        started_d = started_q;
        seq_err_d = seq_err_q;
        if (accept) begin
            if (in_first) begin
                started_d = 1'b1;
            end
            if ((in_first && cnt_q != 6'd0) ||
                (!in_first && cnt_q == 6'd0 && started_q)) begin
                seq_err_d = 1'b1;
            end
        end
    end

    // Sequence-check state, cleared only by reset
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            started_q <= 1'b0;
            seq_err_q <= 1'b0;
        end else begin
            started_q <= started_d;
            seq_err_q <= seq_err_d;
        end
    end
`endif

endmodule

// File: tb/tb_md5_rotadd_stage.sv
// tb_md5_rotadd_stage: directed vectors with hand-computed results.
// A scoreboard queue is filled on input acceptance.
// A negedge monitor drains the queue on every output transfer.
module tb_md5_rotadd_stage;

    logic        CLK = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_first = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] in_sum = '0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        in_ready;
    logic        out_valid;
    logic        out_last;
    logic [31:0] out_b;
    logic [5:0]  out_round;
`ifdef MD5_ROTADD_SEQ_CHECK_EN
    logic        seq_err;
`endif

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] b;
        logic [5:0]  r;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int unsigned acc_cnt = 0;
    int unsigned acc0 = 0;
    logic        bp_done = 1'b0;

    // MD5 rotate amounts by {group, position}, straight from the step table
    int unsigned s_tab[16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};

    always #5 CLK = ~CLK;

    md5_rotadd_stage #(.WIDTH(32)) dut (
        .CLK       (CLK),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_first  (in_first),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_b     (out_b),
        .out_round (out_round),
        .out_last  (out_last)
`ifdef MD5_ROTADD_SEQ_CHECK_EN
        ,
        .seq_err   (seq_err)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rot1(input int step);
        logic [5:0] ix;
        ix = step[5:0];
        return 32'h1 << s_tab[{ix[5:4], ix[1:0]}];
    endfunction

    // Monitor: compare every output transfer against the scoreboard head
    always @(negedge CLK) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got out_b=0x%0h round=%0d expected no output", out_b, out_round);
            end else begin
                mon_e = sb_q.pop_front();
                check("out_b", {32'h0, out_b}, {32'h0, mon_e.b});
                check("out_round", {58'h0, out_round}, {58'h0, mon_e.r});
                check("out_last", {63'h0, out_last}, {63'h0, (mon_e.r == 6'd63)});
            end
        end
        if (rst_n && in_valid && in_ready) acc_cnt++;
    end

    // Drive one input, wait (bounded) for acceptance, then record the expectation
    task automatic send(input logic f, input logic [31:0] a, input logic [31:0] s,
                        input logic [31:0] b, input logic [31:0] exp_b, input logic [5:0] exp_r);
        int unsigned n;
        exp_t e;
        logic timed_out;
        n = 0;
        timed_out = 1'b0;
        in_valid = 1'b1;
        in_first = f;
        in_a = a;
        in_sum = s;
        in_b = b;
        @(negedge CLK);
        while (!in_ready && !timed_out) begin
            n++;
            if (n > 200) begin
                timed_out = 1'b1;
                checks++;
                failures++;
                $display("FAIL accept_timeout: got in_ready=0 for %0d cycles expected acceptance", n);
            end else begin
                @(negedge CLK);
            end
        end
        if (!timed_out) begin
            @(posedge CLK);
            e.b = exp_b;
            e.r = exp_r;
            sb_q.push_back(e);
            #1;
        end
        in_valid = 1'b0;
        in_first = 1'b0;
    endtask

    task automatic drain();
        int unsigned n;
        n = 0;
        while (sb_q.size() != 0 && n < 300) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout: got %0d pending results expected 0", sb_q.size());
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        checks++;
        failures++;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        rst_n = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_out_valid", {63'h0, out_valid}, 64'h0);
        check("rst_out_b", {32'h0, out_b}, 64'h0);
        check("rst_out_round", {58'h0, out_round}, 64'h0);
        check("rst_out_last", {63'h0, out_last}, 64'h0);
        rst_n = 1'b1;
        @(posedge CLK);
        #1;
        check("in_ready_after_reset", {63'h0, in_ready}, 64'h1);

        // Basic latency: step 0, t=1, s=7
        send(1'b1, 32'h0, 32'h1, 32'h0, 32'h0000_0080, 6'd0);
        @(negedge CLK);
        check("latency_cycle1_valid", {63'h0, out_valid}, 64'h0);
        @(negedge CLK);
        check("latency_cycle2_valid", {63'h0, out_valid}, 64'h1);
        @(posedge CLK);
        #1;

        // Backpressure: steps 1..4 offered while the output is stalled
        out_ready = 1'b0;
        acc0 = acc_cnt;
        fork
            begin
                // step 1 also exercises the 2^32 wrap of the final add
                send(1'b0, 32'h1, 32'h0, 32'hFFFF_FFFF, 32'h0000_0FFF, 6'd1);
                send(1'b0, 32'h1, 32'h0, 32'h0000_0200, 32'h0002_0200, 6'd2);
                send(1'b0, 32'h1, 32'h0, 32'h0000_0300, 32'h0040_0300, 6'd3);
                send(1'b0, 32'h1, 32'h0, 32'h0000_0400, 32'h0000_0480, 6'd4);
                bp_done = 1'b1;
            end
        join_none
        repeat (4) @(negedge CLK);
        #1;
        check("bp_accepted", 64'(acc_cnt - acc0), 64'd2);
        check("bp_in_ready", {63'h0, in_ready}, 64'h0);
        @(posedge CLK);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check("bp_no_gap", {63'h0, out_valid}, 64'h1);
        end
        check("bp_all_sent", {63'h0, bp_done}, 64'h1);
        @(posedge CLK);
        #1;

        // Steps 5..9: zero rotate input, out_b = b
        for (int i = 5; i < 10; i++) begin
            send(1'b0, 32'h0, 32'h0, 32'(i * 32'h11), 32'(i * 32'h11), 6'(i));
        end
        drain();
`ifdef MD5_ROTADD_SEQ_CHECK_EN
        check("seq_err_clean", {63'h0, seq_err}, 64'h0);
`endif
        // Restart at step 10: round 0 and s=7 (s=17 would give 0x20000)
        send(1'b1, 32'h1, 32'h0, 32'h0, 32'h0000_0080, 6'd0);
        drain();
`ifdef MD5_ROTADD_SEQ_CHECK_EN
        check("seq_err_restart", {63'h0, seq_err}, 64'h1);
        repeat (3) @(posedge CLK);
        #1;
        check("seq_err_sticky", {63'h0, seq_err}, 64'h1);
`endif

        // Reset mid-flight with two results buffered
        out_ready = 1'b0;
        send(1'b0, 32'h1, 32'h0, 32'h0, 32'h0, 6'd1);
        send(1'b0, 32'h1, 32'h0, 32'h0, 32'h0, 6'd2);
        check("midrst_buffered_valid", {63'h0, out_valid}, 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid_drop", {63'h0, out_valid}, 64'h0);
        sb_q.delete();
        @(negedge CLK);
        rst_n = 1'b1;
        out_ready = 1'b1;
        check("midrst_in_ready", {63'h0, in_ready}, 64'h1);
`ifdef MD5_ROTADD_SEQ_CHECK_EN
        check("seq_err_cleared", {63'h0, seq_err}, 64'h0);
`endif
        @(posedge CLK);
        #1;
        send(1'b0, 32'h1, 32'h0, 32'h0, 32'h0000_0080, 6'd0);
        drain();

        // Full block: step 0 wraps A+sum to 0, steps 1..62 rotate a single bit
        send(1'b1, 32'h8000_0000, 32'h8000_0000, 32'h5, 32'h0000_0005, 6'd0);
        for (int i = 1; i < 63; i++) begin
            send(1'b0, 32'h1, 32'h0, 32'h0, rot1(i), 6'(i));
        end
        send(1'b0, 32'h800, 32'h0, 32'h0, 32'h0000_0001, 6'd63);
        // Counter wrapped to 0: ROTL(0x12345678,7)=0x1A2B3C09, plus 1
        send(1'b0, 32'h0, 32'h1234_5678, 32'h1, 32'h1A2B_3C0A, 6'd0);
        drain();
`ifdef MD5_ROTADD_SEQ_CHECK_EN
        check("seq_err_overrun", {63'h0, seq_err}, 64'h1);
`endif
        check("final_idle", {63'h0, out_valid}, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
